// File: rtl/rvmyth_adc_pkg.sv
// Shared types and defaults for the RVMYTH SAR ADC input path.
// Provides the controller state encoding and default geometry.
package rvmyth_adc_pkg;

   localparam int SAR_WIDTH_DEFAULT  = 10;
   localparam int SAR_SAMPLE_DEFAULT = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SAMPLE  = 2'd1,
      ST_CONVERT = 2'd2,
      ST_DONE    = 2'd3
   } sar_state_t;

endpackage

// File: rtl/rvmyth_sar_seq.sv
// Successive-approximation sequencer: bit pointer plus result register.
// Ports: clk, reset (sync, active-low), load, step, cmp -> trial, result, last.
module rvmyth_sar_seq
   import rvmyth_adc_pkg::*;
#(
   parameter int WIDTH = SAR_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             cmp,
   output logic [WIDTH-1:0] trial,
   output logic [WIDTH-1:0] result,
   output logic             last
);

   localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [PW-1:0] PTR_TOP = PW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [PW-1:0]    ptr;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] onehot;

   assign onehot = ONE << ptr;
   assign trial  = res | onehot;
   assign result = res;
   assign last   = (ptr == '0);

   // The tested bit is always still 0 when it is resolved,
   // so clearing it on cmp=0 is only for robustness.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr <= '0;
         res <= '0;
      end else if (load) begin
         ptr <= PTR_TOP;
         res <= '0;
      end else if (step) begin
         res <= cmp ? (res | onehot) : (res & ~onehot);
         if (ptr != '0) begin
            ptr <= ptr - 1'b1;
         end
      end
   end

endmodule

// File: rtl/rvmyth_sar_adc_ctrl.sv
// SAR ADC controller driving avsddac D and reading an external comparator.
// Ports: clk, reset, start, cmp, ready -> dac_code, sample_en, busy, data, valid.
// The integrating top ties the DAC enable high while this block is active.
module rvmyth_sar_adc_ctrl
   import rvmyth_adc_pkg::*;
#(
   parameter int WIDTH         = SAR_WIDTH_DEFAULT,
   parameter int SAMPLE_CYCLES = SAR_SAMPLE_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             cmp,
   output logic [WIDTH-1:0] dac_code,
   output logic             sample_en,
   output logic             busy,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   input  logic             ready
);

   localparam logic [3:0] SCNT_LAST = 4'(SAMPLE_CYCLES - 1);

   sar_state_t       state;
   logic [3:0]       scnt;
   logic             load;
   logic             step;
   logic             last;
   logic [WIDTH-1:0] trial;
   logic [WIDTH-1:0] result;

   // Holding load through IDLE and SAMPLE leaves the sequencer
   // primed with the MSB pointer and a clear result on entry to CONVERT.
   assign load = (state == ST_IDLE) || (state == ST_SAMPLE);
   assign step = (state == ST_CONVERT);

   rvmyth_sar_seq #(
      .WIDTH (WIDTH)
   ) u_seq (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .step   (step),
      .cmp    (cmp),
      .trial  (trial),
      .result (result),
      .last   (last)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_IDLE;
         scnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               scnt <= '0;
               if (start) begin
                  state <= ST_SAMPLE;
               end
            end
            ST_SAMPLE: begin
               if (scnt == SCNT_LAST) begin
                  scnt  <= '0;
                  state <= ST_CONVERT;
               end else begin
                  scnt <= scnt + 4'd1;
               end
            end
            ST_CONVERT: begin
               if (last) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (ready) begin
                  state <= start ? ST_SAMPLE : ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
               scnt  <= '0;
            end
         endcase
      end
   end

   // Outputs decode registered state only; no input reaches them.
   always_comb begin
      dac_code  = '0;
      sample_en = 1'b0;
      busy      = 1'b0;
      data      = '0;
      valid     = 1'b0;
      case (state)
         ST_SAMPLE: begin
            sample_en = 1'b1;
            busy      = 1'b1;
         end
         ST_CONVERT: begin
            busy     = 1'b1;
            dac_code = trial;
         end
         ST_DONE: begin
            valid    = 1'b1;
            data     = result;
            dac_code = result;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_rvmyth_sar_adc_ctrl.sv
// Directed bench for rvmyth_sar_adc_ctrl with a behavioural comparator.
// Expected results are queued at start and checked when valid appears.
module tb_rvmyth_sar_adc_ctrl;

   logic       clk;
   logic       reset;
   logic       start;
   logic       cmp;
   logic       ready;
   logic [9:0] dac_code;
   logic [9:0] data;
   logic       sample_en;
   logic       busy;
   logic       valid;
   logic [9:0] x;

   int tests;
   int fails;
   logic [9:0] sb[$];
   logic [9:0] nom_tab [10] = '{
      10'h200, 10'h300, 10'h280, 10'h2C0, 10'h2A0,
      10'h2B0, 10'h2A8, 10'h2A4, 10'h2A6, 10'h2A5
   };

   rvmyth_sar_adc_ctrl #(
      .WIDTH         (10),
      .SAMPLE_CYCLES (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .cmp       (cmp),
      .dac_code  (dac_code),
      .sample_en (sample_en),
      .busy      (busy),
      .data      (data),
      .valid     (valid),
      .ready     (ready)
   );

   assign cmp = (dac_code <= x);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_dac"}, dac_code, 0);
      chk({tag, "_sen"}, sample_en, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_data"}, data, 0);
      chk({tag, "_valid"}, valid, 0);
   endtask

   task automatic pop_chk(input string tag);
      logic [9:0] e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 1, 0);
      end else begin
         e = sb.pop_front();
         chk({tag, "_data"}, data, e);
      end
   endtask

   // Starts at cycle 0 and returns during cycle 13 (valid expected).
   task automatic run_conv(input string tag, input logic [9:0] xv,
                           input bit use_tab, input int pulse_c,
                           input bit hold);
      logic [9:0] r;
      logic [9:0] t;
      int i;
      r = '0;
      x = xv;
      start = 1'b1;
      sb.push_back(xv);
      tick();
      if (!hold) start = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         chk($sformatf("%s_busy_c%0d", tag, c), busy, 1);
         if (c <= 2) begin
            chk($sformatf("%s_sen_c%0d", tag, c), sample_en, 1);
            chk($sformatf("%s_sdac_c%0d", tag, c), dac_code, 0);
         end else begin
            i = 12 - c;
            t = r | (10'd1 << i);
            chk($sformatf("%s_sen_c%0d", tag, c), sample_en, 0);
            if (use_tab)
               chk($sformatf("%s_dac_c%0d", tag, c), dac_code, nom_tab[c-3]);
            else
               chk($sformatf("%s_dac_c%0d", tag, c), dac_code, t);
            if (t <= xv) r = t;
         end
         if (c == pulse_c) start = 1'b1;
         tick();
         if (c == pulse_c) start = 1'b0;
      end
      chk({tag, "_valid"}, valid, 1);
      chk({tag, "_busy13"}, busy, 0);
      chk({tag, "_dac13"}, dac_code, r);
      pop_chk(tag);
   endtask

   initial begin
      int n;
      tests = 0;
      fails = 0;
      reset = 1'b0;
      start = 1'b0;
      ready = 1'b0;
      x     = '0;
      tick();
      tick();
      chk_idle("rst");
      reset = 1'b1;
      tick();
      chk_idle("idle");

      ready = 1'b1;
      run_conv("nom", 10'h2A5, 1'b1, 0, 1'b0);
      tick();
      chk("nom_after_valid", valid, 0);
      chk("nom_after_busy", busy, 0);

      run_conv("zero", 10'h000, 1'b0, 0, 1'b0);
      tick();
      run_conv("full", 10'h3FF, 1'b0, 0, 1'b0);
      tick();
      chk_idle("full_after");

      ready = 1'b0;
      run_conv("bp", 10'h155, 1'b0, 0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("bp_hold_valid%0d", k), valid, 1);
         chk($sformatf("bp_hold_data%0d", k), data, 10'h155);
      end
      ready = 1'b1;
      tick();
      chk("bp_accept_valid", valid, 0);
      chk("bp_accept_busy", busy, 0);

      run_conv("ign", 10'h2C3, 1'b0, 7, 1'b0);
      tick();
      chk("ign_valid14", valid, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("ign_idle_busy%0d", k), busy, 0);
         chk($sformatf("ign_idle_valid%0d", k), valid, 0);
      end

      run_conv("b2b1", 10'h1E7, 1'b0, 0, 1'b1);
      x = 10'h3C3;
      sb.push_back(10'h3C3);
      n = 0;
      do begin
         tick();
         n++;
         if (n == 1) chk("b2b_sample_next", sample_en, 1);
      end while (!valid && n < 40);
      chk("b2b_latency", n, 13);
      pop_chk("b2b2");
      start = 1'b0;
      tick();
      chk("b2b_after_valid", valid, 0);
      chk("b2b_after_busy", busy, 0);

      x = 10'h2A5;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      chk("mid_busy_c6", busy, 1);
      reset = 1'b0;
      tick();
      chk_idle("midrst");
      reset = 1'b1;
      for (int k = 0; k < 15; k++) begin
         tick();
         chk($sformatf("midrst_novalid%0d", k), valid, 0);
      end
      run_conv("post", 10'h0F0, 1'b0, 0, 1'b0);
      tick();
      chk("post_after_valid", valid, 0);

      chk("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
